fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that shares the single write port of the team's synchronous fifo (clk/rst_n, wr_en/wr_data, full) among NUM_REQ producers. Grants are burst-locked, so one requester owns the port for up to MAX_BURST accepted words before priority rotates. Backpressure from fifo full is propagated to the granted producer only. Sits directly in front of fifo_inst; the fifo read side is untouched.

---
 rtl/fifo_wr_arbiter.sv | 129 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Burst-locked round-robin arbiter sharing one fifo write port among NUM_REQ producers.
// One IDLE cycle per grant, then up to MAX_BURST words; fifo_full stalls only the granted producer.
module fifo_wr_arbiter #(
  parameter int data_width = 100,
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2,
  parameter int MAX_BURST  = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*data_width-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            fifo_full,
  output logic                            fifo_wr_en,
  output logic [data_width-1:0]           fifo_wr_data,
  output logic [ID_WIDTH-1:0]             grant_id,
  output logic                            busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [ID_WIDTH-1:0] LAST_RST  = ID_WIDTH'(NUM_REQ - 1);
  localparam logic [3:0]          LAST_BEAT = 4'(MAX_BURST - 1);

  state_t                state_q, state_d;
  logic [ID_WIDTH-1:0]   grant_q, grant_d;
  logic [ID_WIDTH-1:0]   last_q, last_d;
  logic [3:0]            beat_q, beat_d;
  logic [ID_WIDTH-1:0]   pick;
  logic                  any_vld;
  logic                  owner_vld;
  logic [data_width-1:0] sel_data;

  assign any_vld   = |req_valid;
  assign owner_vld = req_valid[grant_q];
  assign busy      = (state_q == GRANT);
  assign grant_id  = grant_q;

  // Search starts just after the previous owner and wraps modulo NUM_REQ,
  // so non-power-of-2 requester counts never land on an unused index.
  always_comb begin
    int                  idx;
    logic                found;
    logic [ID_WIDTH-1:0] cand;
    idx   = 0;
    cand  = '0;
    found = 1'b0;
    pick  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = int'(last_q) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      cand = ID_WIDTH'(idx);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == ID_WIDTH'(i)) begin
        sel_data = req_data[i*data_width +: data_width];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (busy && !fifo_full) begin
      req_ready[grant_q] = 1'b1;
    end
  end

  assign fifo_wr_en   = busy && owner_vld && !fifo_full;
  assign fifo_wr_data = fifo_wr_en ? sel_data : '0;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (any_vld) begin
          grant_d = pick;
          beat_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // A producer gap releases the port; a full fifo merely holds the burst.
        if (!owner_vld) begin
          last_d  = grant_q;
          state_d = IDLE;
        end else if (!fifo_full) begin
          beat_d = beat_q + 4'd1;
          if (beat_q == LAST_BEAT) begin
            last_d  = grant_q;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LAST_RST;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized producers and fifo_full against a burst-level reference model; expected
// per-cycle outputs and expected fifo writes are queued and consumed by a separate monitor.
module tb_fifo_wr_arbiter;

  localparam int DW = 100;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_full;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_wr_data;
  logic [IW-1:0]   grant_id;
  logic            busy;

  fifo_wr_arbiter #(
    .data_width(DW), .NUM_REQ(N), .ID_WIDTH(IW), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] ready;
    logic         wr;
    logic         busy;
    int           grant;
    bit           chk_grant;
  } cyc_t;

  typedef struct {
    int          id;
    logic [DW-1:0] d;
  } wr_t;

  cyc_t cq[$];
  wr_t  wq[$];

  int errors = 0;
  int checks = 0;

  // Producer state: a word stays valid until the model says it was accepted.
  bit            vld[N];
  bit            acc[N];
  logic [DW-1:0] dat[N];
  int            seqn[N];

  // Reference model: who owns the port, how many words it has moved, who owned it last.
  bit m_gnt;
  int m_own;
  int m_taken;
  int m_last;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mk_word(input int id);
    logic [DW-1:0] w;
    w        = '0;
    w[31:0]  = $urandom;
    w[63:32] = $urandom;
    w[79:64] = 16'($urandom);
    w[95:80] = 16'(seqn[id]);
    w[99:96] = 4'(id);
    seqn[id]++;
    return w;
  endfunction

  task automatic step(input logic [N-1:0] mask, input int p_vld, input int p_full, input bit rst);
    cyc_t rec;
    wr_t  w;
    bit   found;
    bit   full;
    int   c;
    @(negedge clk);
    rst_n = !rst;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        vld[i] = 1'b0;
        acc[i] = 1'b0;
      end
      if (!vld[i] && mask[i] && ($urandom_range(99) < p_vld)) begin
        vld[i] = 1'b1;
        dat[i] = mk_word(i);
      end
      req_valid[i]           = vld[i];
      req_data[i*DW +: DW]   = dat[i];
    end
    full      = ($urandom_range(99) < p_full);
    fifo_full = full;

    rec.ready     = '0;
    rec.wr        = 1'b0;
    rec.busy      = 1'b0;
    rec.grant     = 0;
    rec.chk_grant = 1'b0;
    if (rst) begin
      m_gnt         = 1'b0;
      m_last        = N - 1;
      m_taken       = 0;
      rec.chk_grant = 1'b1;
    end else if (!m_gnt) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (!found && vld[c]) begin
          found = 1'b1;
          m_own = c;
        end
      end
      if (found) begin
        m_gnt   = 1'b1;
        m_taken = 0;
      end
    end else begin
      rec.busy      = 1'b1;
      rec.chk_grant = 1'b1;
      rec.grant     = m_own;
      if (!full) rec.ready[m_own] = 1'b1;
      if (vld[m_own] && !full) begin
        rec.wr  = 1'b1;
        w.id    = m_own;
        w.d     = dat[m_own];
        wq.push_back(w);
        acc[m_own] = 1'b1;
        m_taken++;
        if (m_taken == MB) begin
          m_gnt  = 1'b0;
          m_last = m_own;
        end
      end else if (!vld[m_own]) begin
        m_gnt  = 1'b0;
        m_last = m_own;
      end
    end
    cq.push_back(rec);
  endtask

  initial begin
    cyc_t r;
    wr_t  w;
    forever begin
      @(negedge clk);
      #2;
      if (cq.size() != 0) begin
        r = cq.pop_front();
        chk("req_ready", 128'(req_ready), 128'(r.ready));
        chk("fifo_wr_en", 128'(fifo_wr_en), 128'(r.wr));
        chk("busy", 128'(busy), 128'(r.busy));
        chk("no_write_when_full", 128'(fifo_wr_en & fifo_full), 128'(0));
        if (r.chk_grant) chk("grant_id", 128'(grant_id), 128'(r.grant));
        if (fifo_wr_en) begin
          if (wq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got data %0h expected no write at %0t", fifo_wr_data, $time);
          end else begin
            w = wq.pop_front();
            chk("wr_data", 128'(fifo_wr_data), 128'(w.d));
            chk("wr_owner", 128'(grant_id), 128'(w.id));
          end
        end else begin
          chk("idle_wr_data", 128'(fifo_wr_data), 128'(0));
        end
      end
    end
  end

  initial begin
    int rst_left;
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < N; i++) begin
      vld[i]  = 1'b0;
      acc[i]  = 1'b0;
      dat[i]  = '0;
      seqn[i] = 0;
    end
    m_gnt = 1'b0; m_own = 0; m_taken = 0; m_last = N - 1;

    repeat (2) step(4'hf, 100, 0, 1'b1);
    repeat (60) step(4'hf, 100, 0, 1'b0);
    repeat (40) step(4'b0100, 100, 0, 1'b0);
    repeat (60) step(4'b0010, 100, 40, 1'b0);
    rst_left = 0;
    for (int n = 0; n < 3000; n++) begin
      if (rst_left == 0 && $urandom_range(99) == 0) rst_left = $urandom_range(1, 3);
      step(4'hf, 60, 30, rst_left != 0);
      if (rst_left != 0) rst_left--;
    end
    repeat (300) step(4'hf, 100, 50, 1'b0);
    repeat (40) step(4'h0, 0, 0, 1'b0);

    @(negedge clk);
    #5;
    chk("unconsumed_cycles", 128'(cq.size()), 128'(0));
    chk("missing_writes", 128'(wq.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
